// File: rtl/usart_tx_engine.sv
// USART transmit engine: UDR holding buffer plus shift register
// serialising start, 5-9 data bits, optional parity and 1/2 stops.
module usart_tx_engine #(
  parameter int OVS_NORM = 16,
  parameter int OVS_U2X  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_clk_en,
  input  logic       txen,
  input  logic       u2x,
  input  logic [2:0] chsz,
  input  logic [1:0] upm,
  input  logic       usbs,
  input  logic       udr_wr,
  input  logic [7:0] udr_wdata,
  input  logic       txb8,
  input  logic       txc_clr,
  output logic       udre,
  output logic       txc,
  output logic       tx_busy,
  output logic       clr_tx_cnt,
  output logic       txd
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t     state, state_n;
  logic [3:0] sample_cnt;
  logic [3:0] bit_cnt;
  logic [8:0] buf_q;
  logic [8:0] shreg;
  logic [3:0] nb_last_q;
  logic       par_en_q;
  logic       par_q;
  logic       usbs_q;
  logic       u2x_q;

  logic [3:0] ovs_last;
  logic       bit_end;
  logic       wr_ok;
  logic       load;
  logic       finish;
  logic       set_txc;
  logic       txd_n;
  logic [3:0] nb_last_in;
  logic [8:0] mask_in;
  logic       par_in;

  assign ovs_last = u2x_q ? 4'(OVS_U2X - 1) : 4'(OVS_NORM - 1);
  assign bit_end  = tx_clk_en && (sample_cnt == ovs_last);
  assign wr_ok    = udr_wr && udre && txen;
  assign tx_busy  = (state != IDLE);

  always_comb begin
    nb_last_in = 4'd7;
    mask_in    = 9'h0ff;
    unique case (chsz)
      3'b000:  begin nb_last_in = 4'd4; mask_in = 9'h01f; end
      3'b001:  begin nb_last_in = 4'd5; mask_in = 9'h03f; end
      3'b010:  begin nb_last_in = 4'd6; mask_in = 9'h07f; end
      3'b111:  begin nb_last_in = 4'd8; mask_in = 9'h1ff; end
      default: begin nb_last_in = 4'd7; mask_in = 9'h0ff; end
    endcase
    par_in = (^(buf_q & mask_in)) ^ upm[0];
  end

  always_comb begin
    state_n = state;
    txd_n   = txd;
    load    = 1'b0;
    finish  = 1'b0;
    set_txc = 1'b0;
    if (!txen) begin
      state_n = IDLE;
      txd_n   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          txd_n = 1'b1;
          if (!udre) load = 1'b1;
        end
        START: if (bit_end) begin
          state_n = DATA;
          txd_n   = shreg[0];
        end
        DATA: if (bit_end) begin
          if (bit_cnt == nb_last_q) begin
            state_n = par_en_q ? PARITY : STOP1;
            txd_n   = par_en_q ? par_q : 1'b1;
          end else begin
            txd_n = shreg[0];
          end
        end
        PARITY: if (bit_end) begin
          state_n = STOP1;
          txd_n   = 1'b1;
        end
        STOP1: if (bit_end) begin
          if (usbs_q) begin
            state_n = STOP2;
            txd_n   = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end
        STOP2: if (bit_end) finish = 1'b1;
        default: state_n = IDLE;
      endcase
      // a full buffer at frame end chains straight into the next start bit
      if (finish) begin
        if (!udre) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
          txd_n   = 1'b1;
          set_txc = 1'b1;
        end
      end
      if (load) begin
        state_n = START;
        txd_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      txd        <= 1'b1;
      udre       <= 1'b1;
      txc        <= 1'b0;
      clr_tx_cnt <= 1'b0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      buf_q      <= '0;
      shreg      <= '0;
      nb_last_q  <= 4'd7;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      usbs_q     <= 1'b0;
      u2x_q      <= 1'b0;
    end else begin
      state      <= state_n;
      txd        <= txd_n;
      clr_tx_cnt <= load;
      if (load || !txen) sample_cnt <= '0;
      else if (tx_clk_en) sample_cnt <= bit_end ? '0 : sample_cnt + 4'd1;
      if (state == START && bit_end) bit_cnt <= '0;
      else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 4'd1;
      if (load) begin
        shreg     <= buf_q;
        nb_last_q <= nb_last_in;
        par_en_q  <= upm[1];
        par_q     <= par_in;
        usbs_q    <= usbs;
        u2x_q     <= u2x;
      end else if (txen && bit_end && (state == START || state == DATA)) begin
        shreg <= {1'b0, shreg[8:1]};
      end
      if (!txen || load) begin
        udre <= 1'b1;
      end else if (wr_ok) begin
        buf_q <= {txb8, udr_wdata};
        udre  <= 1'b0;
      end
      if (set_txc) txc <= 1'b1;
      else if (txc_clr) txc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usart_tx_engine.sv
// Directed bench for usart_tx_engine: frame shapes, chaining,
// abort, dropped writes, txc priority and mid-frame reset.
module tb_usart_tx_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_clk_en = 1'b1;
  logic       txen = 1'b0;
  logic       u2x = 1'b0;
  logic [2:0] chsz = 3'b011;
  logic [1:0] upm = 2'b00;
  logic       usbs = 1'b0;
  logic       udr_wr = 1'b0;
  logic [7:0] udr_wdata = 8'h00;
  logic       txb8 = 1'b0;
  logic       txc_clr = 1'b0;
  logic       udre, txc, tx_busy, clr_tx_cnt, txd;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;

  usart_tx_engine dut (
    .clk(clk), .rst(rst), .tx_clk_en(tx_clk_en), .txen(txen),
    .u2x(u2x), .chsz(chsz), .upm(upm), .usbs(usbs),
    .udr_wr(udr_wr), .udr_wdata(udr_wdata), .txb8(txb8),
    .txc_clr(txc_clr), .udre(udre), .txc(txc), .tx_busy(tx_busy),
    .clr_tx_cnt(clr_tx_cnt), .txd(txd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (clr_tx_cnt) clr_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d, input logic b8);
    udr_wr = 1'b1;
    udr_wdata = d;
    txb8 = b8;
    step();
    udr_wr = 1'b0;
  endtask

  task automatic expect_frame(input logic [15:0] f, input int nb,
                              input int per, input logic do_wr,
                              input logic [7:0] wd,
                              input logic clr_last, input string nm);
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < per; j++) begin
        checks++;
        if (txd !== f[i]) begin
          errors++;
          $display("FAIL %s bit%0d cyc%0d txd=%b want %b",
                   nm, i, j, txd, f[i]);
        end
        if (do_wr && i == 1 && j == 0) begin
          checks++;
          if (udre !== 1'b0) begin
            errors++;
            $display("FAIL %s udre_full udre=%b want 0", nm, udre);
          end
        end
        if (do_wr && i == 0 && j == 0) begin
          udr_wr = 1'b1;
          udr_wdata = wd;
          txb8 = 1'b0;
        end
        if (clr_last && i == nb - 1 && j == per - 1) txc_clr = 1'b1;
        step();
        udr_wr = 1'b0;
        txc_clr = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({txd, udre, txc, tx_busy, clr_tx_cnt} !== 5'b11000) begin
      errors++;
      $display("FAIL reset outs=%b want 11000",
               {txd, udre, txc, tx_busy, clr_tx_cnt});
    end
    rst = 1'b0;
    txen = 1'b1;
    step();
  endtask

  task automatic test_frame_8n1();
    int c0;
    c0 = clr_cnt;
    do_write(8'h55, 1'b0);
    step();
    checks++;
    if (tx_busy !== 1'b1 || udre !== 1'b1) begin
      errors++;
      $display("FAIL t1_load busy=%b udre=%b want 1 1", tx_busy, udre);
    end
    expect_frame({1'b1, 8'h55, 1'b0}, 10, 16, 1'b0, 8'h00, 1'b0, "t1");
    checks++;
    if (txc !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_end txc=%b busy=%b want 1 0", txc, tx_busy);
    end
    checks++;
    if (clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL t1_clr pulses=%0d want 1", clr_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    txc_clr = 1'b1;
    step();
    txc_clr = 1'b0;
    c0 = clr_cnt;
    do_write(8'hA3, 1'b0);
    step();
    expect_frame({1'b1, 8'hA3, 1'b0}, 10, 16, 1'b1, 8'h0F, 1'b0, "t2a");
    checks++;
    if (txc !== 1'b0 || udre !== 1'b1) begin
      errors++;
      $display("FAIL t2_mid txc=%b udre=%b want 0 1", txc, udre);
    end
    expect_frame({1'b1, 8'h0F, 1'b0}, 10, 16, 1'b0, 8'h00, 1'b0, "t2b");
    checks++;
    if (txc !== 1'b1) begin
      errors++;
      $display("FAIL t2_end txc=%b want 1", txc);
    end
    checks++;
    if (clr_cnt - c0 != 2) begin
      errors++;
      $display("FAIL t2_clr pulses=%0d want 2", clr_cnt - c0);
    end
  endtask

  task automatic test_9bit_odd_2stop();
    chsz = 3'b111;
    upm = 2'b11;
    usbs = 1'b1;
    do_write(8'h00, 1'b1);
    step();
    expect_frame({1'b1, 1'b1, 1'b0, 9'h100, 1'b0}, 13, 16,
                 1'b0, 8'h00, 1'b0, "t3");
    checks++;
    if (txc !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL t3_end txc=%b busy=%b want 1 0", txc, tx_busy);
    end
  endtask

  task automatic test_u2x_5bit_even();
    u2x = 1'b1;
    chsz = 3'b000;
    upm = 2'b10;
    usbs = 1'b0;
    do_write(8'h1B, 1'b0);
    step();
    expect_frame({1'b1, 1'b0, 5'h1B, 1'b0}, 8, 8,
                 1'b0, 8'h00, 1'b0, "t4");
    checks++;
    if (tx_busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL t4_end busy=%b txd=%b want 0 1", tx_busy, txd);
    end
    u2x = 1'b0;
    chsz = 3'b011;
    upm = 2'b00;
  endtask

  task automatic test_abort();
    int c0;
    do_write(8'h55, 1'b0);
    step();
    do_write(8'hFF, 1'b0);
    repeat (50) step();
    checks++;
    if (udre !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL t5_pre udre=%b busy=%b want 0 1", udre, tx_busy);
    end
    c0 = clr_cnt;
    txen = 1'b0;
    step();
    checks++;
    if ({txd, tx_busy, udre, txc} !== 4'b1011) begin
      errors++;
      $display("FAIL t5_abort txd/busy/udre/txc=%b want 1011",
               {txd, tx_busy, udre, txc});
    end
    txen = 1'b1;
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (txd !== 1'b1 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL t5_idle cyc%0d txd=%b busy=%b want 1 0",
                 k, txd, tx_busy);
      end
      step();
    end
    checks++;
    if (clr_cnt != c0) begin
      errors++;
      $display("FAIL t5_clr pulses=%0d want 0", clr_cnt - c0);
    end
  endtask

  task automatic test_drop_txc_rst();
    txc_clr = 1'b1;
    step();
    txc_clr = 1'b0;
    checks++;
    if (txc !== 1'b0) begin
      errors++;
      $display("FAIL t6_clr txc=%b want 0", txc);
    end
    do_write(8'h00, 1'b0);
    udr_wr = 1'b1;
    udr_wdata = 8'hFF;
    step();
    udr_wr = 1'b0;
    checks++;
    if (udre !== 1'b1) begin
      errors++;
      $display("FAIL t6_drop udre=%b want 1", udre);
    end
    expect_frame({1'b1, 8'h00, 1'b0}, 10, 16, 1'b0, 8'h00, 1'b1, "t6");
    checks++;
    if (txc !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL t6_setwins txc=%b busy=%b want 1 0", txc, tx_busy);
    end
    do_write(8'h3C, 1'b0);
    step();
    repeat (30) step();
    rst = 1'b1;
    step();
    checks++;
    if ({txd, udre, txc, tx_busy, clr_tx_cnt} !== 5'b11000) begin
      errors++;
      $display("FAIL t6_rst outs=%b want 11000",
               {txd, udre, txc, tx_busy, clr_tx_cnt});
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_frame_8n1();
    test_back_to_back();
    test_9bit_odd_2stop();
    test_u2x_5bit_even();
    test_abort();
    test_drop_txc_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
